// File: rtl/snake_body_if.sv
// Head, pixel and colour signals between the snake body and its neighbours.
// master drives head position, game state and pixel scan; slave is the body block.
interface snake_body_if;
  logic [11:0] head_x;
  logic [11:0] head_y;
  logic        game_over_in;
  logic        grow;
  logic [11:0] x;
  logic [11:0] y;
  logic        body_on;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        self_hit;
  logic [4:0]  length;

  modport master (
    output head_x, head_y, game_over_in, grow, x, y,
    input  body_on, vga_r, vga_g, vga_b, self_hit, length
  );

  modport slave (
    input  head_x, head_y, game_over_in, grow, x, y,
    output body_on, vga_r, vga_g, vga_b, self_hit, length
  );
endinterface

// File: rtl/snake_body.sv
// Snake body tracker: shifts segment history on each head move, handles growth,
// detects head-into-body collision and renders body pixels for the VGA scan.
module snake_body #(
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned INIT_LEN  = 3,
  parameter int unsigned SEG_SIZE  = 20,
  parameter int unsigned MOVE_STEP = 10,
  parameter int unsigned HEAD_X0   = 310,
  parameter int unsigned HEAD_Y0   = 230
) (
  input  logic         CLOCK_50,
  input  logic         SW,
  snake_body_if.slave  bus
);

  localparam int unsigned CW = 12;
  localparam int unsigned LW = 5;
  localparam int unsigned BW = 13;

  logic [CW-1:0] seg_x_q [MAX_LEN];
  logic [CW-1:0] seg_y_q [MAX_LEN];
  logic [CW-1:0] seg_x_d [MAX_LEN];
  logic [CW-1:0] seg_y_d [MAX_LEN];
  logic [CW-1:0] prev_x_q, prev_x_d;
  logic [CW-1:0] prev_y_q, prev_y_d;
  logic [LW-1:0] len_q, len_d;
  logic          grow_pend_q, grow_pend_d;
  logic          self_hit_q, self_hit_d;

  logic frozen_c;
  logic move_c;
  logic hit_c;
  logic body_on_c;

  // Next-state: shift on a move, grow bookkeeping, sticky collision.
  always_comb begin
    seg_x_d     = seg_x_q;
    seg_y_d     = seg_y_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    len_d       = len_q;
    grow_pend_d = grow_pend_q;
    self_hit_d  = self_hit_q;
    hit_c       = 1'b0;

    frozen_c = bus.game_over_in | self_hit_q;
    move_c   = !frozen_c && ((bus.head_x != prev_x_q) || (bus.head_y != prev_y_q));

    // Tail segment is excluded: it vacates on the same move.
    for (int i = 0; i < MAX_LEN; i++) begin
      if (((LW'(i) + LW'(1)) < len_q) &&
          (seg_x_q[i] == bus.head_x) && (seg_y_q[i] == bus.head_y))
        hit_c = 1'b1;
    end

    if (move_c) begin
      seg_x_d[0] = prev_x_q;
      seg_y_d[0] = prev_y_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
      prev_x_d = bus.head_x;
      prev_y_d = bus.head_y;
      if ((grow_pend_q || bus.grow) && (len_q < LW'(MAX_LEN)))
        len_d = len_q + LW'(1);
      grow_pend_d = 1'b0;
      if (hit_c)
        self_hit_d = 1'b1;
    end else if (!frozen_c && bus.grow) begin
      grow_pend_d = 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge SW) begin
    if (!SW) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= CW'(HEAD_X0 - MOVE_STEP * (32'(i) + 32'd1));
        seg_y_q[i] <= CW'(HEAD_Y0);
      end
      prev_x_q    <= CW'(HEAD_X0);
      prev_y_q    <= CW'(HEAD_Y0);
      len_q       <= LW'(INIT_LEN);
      grow_pend_q <= 1'b0;
      self_hit_q  <= 1'b0;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      prev_x_q    <= prev_x_d;
      prev_y_q    <= prev_y_d;
      len_q       <= len_d;
      grow_pend_q <= grow_pend_d;
      self_hit_q  <= self_hit_d;
    end
  end

  // Pixel hit test; bounds widened by one bit so seg+SEG_SIZE cannot wrap.
  always_comb begin
    body_on_c = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LW'(i) < len_q) &&
          ({1'b0, bus.x} >= {1'b0, seg_x_q[i]}) &&
          ({1'b0, bus.x} <  ({1'b0, seg_x_q[i]} + BW'(SEG_SIZE))) &&
          ({1'b0, bus.y} >= {1'b0, seg_y_q[i]}) &&
          ({1'b0, bus.y} <  ({1'b0, seg_y_q[i]} + BW'(SEG_SIZE))))
        body_on_c = 1'b1;
    end
  end

  assign bus.body_on  = body_on_c;
  assign bus.vga_r    = 8'd0;
  assign bus.vga_g    = body_on_c ? 8'd128 : 8'd0;
  assign bus.vga_b    = 8'd0;
  assign bus.self_hit = self_hit_q;
  assign bus.length   = len_q;

endmodule
